param_register_file: RTL and testbench

- Parametrised successor to the single-width CPU register file.
- Configurable data width, depth and number of combinational read ports; optional hardwired-zero entry 0 and write-to-read bypass.
- Adds a sequential clear engine, started by reset or on request, that zeroes one entry per cycle and reports busy/done.
- Sits between decode and execute; also serves as the scratch register bank beside the tensor core.

---
 rtl/param_register_file_pkg.sv | 14 +
 rtl/param_register_file_if.sv | 43 ++++
 rtl/register_file_read_port.sv | 34 +++
 rtl/param_register_file.sv | 121 ++++++++++++
 tb/tb_param_register_file.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/param_register_file_pkg.sv
// param_register_file_pkg: shared FSM state type and address-width helper
// for the parametrised register file and its read ports.
package param_register_file_pkg;

  typedef enum logic {
    RF_IDLE,
    RF_CLEARING
  } rf_state_t;

  function automatic int rf_addr_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/param_register_file_if.sv
// param_register_file_if: write strobe/address/data, per-port read address
// and data, clear request, busy and clear-done status. master drives, slave is the file.
interface param_register_file_if #(
  parameter int DATA_WIDTH           = 8,
  parameter int NUMBER_OF_REGISTERS  = 256,
  parameter int NUMBER_OF_READ_PORTS = 2
) ();
  import param_register_file_pkg::*;

  localparam int AW = rf_addr_width(NUMBER_OF_REGISTERS);

  logic                                             write_enable_in;
  logic [AW-1:0]                                    write_register_address_in;
  logic [DATA_WIDTH-1:0]                            write_data_in;
  logic [NUMBER_OF_READ_PORTS-1:0][AW-1:0]          read_register_address_in;
  logic [NUMBER_OF_READ_PORTS-1:0][DATA_WIDTH-1:0]  read_data_out;
  logic                                             clear_request_in;
  logic                                             busy_out;
  logic                                             clear_done_out;

  modport master (
    output write_enable_in,
    output write_register_address_in,
    output write_data_in,
    output read_register_address_in,
    output clear_request_in,
    input  read_data_out,
    input  busy_out,
    input  clear_done_out
  );

  modport slave (
    input  write_enable_in,
    input  write_register_address_in,
    input  write_data_in,
    input  read_register_address_in,
    input  clear_request_in,
    output read_data_out,
    output busy_out,
    output clear_done_out
  );

endinterface

// File: rtl/register_file_read_port.sv
// register_file_read_port: one combinational read port. Inputs: entry array,
// read address, FSM state, pending write; output: read data with bypass/zero/clear masks.
module register_file_read_port
  import param_register_file_pkg::*;
#(
  parameter int DATA_WIDTH          = 8,
  parameter int NUMBER_OF_REGISTERS = 256,
  parameter int ADDR_WIDTH          = 8,
  parameter int HARDWIRED_ZERO      = 1,
  parameter int BYPASS_ENABLE       = 1
) (
  input  logic [DATA_WIDTH-1:0] entries_in [NUMBER_OF_REGISTERS],
  input  logic [ADDR_WIDTH-1:0] read_addr_in,
  input  rf_state_t             state_in,
  input  logic                  write_valid_in,
  input  logic [ADDR_WIDTH-1:0] write_addr_in,
  input  logic [DATA_WIDTH-1:0] write_data_in,
  output logic [DATA_WIDTH-1:0] read_data_out
);

  logic hit;

  // write_valid_in already excludes clears and discarded zero-entry writes
  assign hit = (BYPASS_ENABLE != 0) && write_valid_in
            && (write_addr_in == read_addr_in);

  always_comb begin
    read_data_out = entries_in[read_addr_in];
    if (hit) read_data_out = write_data_in;
    if ((HARDWIRED_ZERO != 0) && (read_addr_in == '0)) read_data_out = '0;
    if (state_in == RF_CLEARING) read_data_out = '0;
  end

endmodule

// File: rtl/param_register_file.sv
// param_register_file: parametrised register file with clear engine.
// Ports: clock_in, reset_in (sync, active high), bus (write, reads, clear, busy, done).
module param_register_file
  import param_register_file_pkg::*;
#(
  parameter int DATA_WIDTH           = 8,
  parameter int NUMBER_OF_REGISTERS  = 256,
  parameter int NUMBER_OF_READ_PORTS = 2,
  parameter int HARDWIRED_ZERO       = 1,
  parameter int BYPASS_ENABLE        = 1
) (
  input logic                 clock_in,
  input logic                 reset_in,
  param_register_file_if.slave bus
);

  localparam int AW = rf_addr_width(NUMBER_OF_REGISTERS);
  localparam logic [AW-1:0] LAST = AW'(NUMBER_OF_REGISTERS - 1);

  rf_state_t state_q, state_d;
  logic [AW-1:0] count_q, count_d;
  logic done_q, done_d;

  logic [DATA_WIDTH-1:0] mem_q [NUMBER_OF_REGISTERS];
  logic                  wr_en_d;
  logic [AW-1:0]         wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d;

  logic user_wr;
  logic zero_drop;

  assign zero_drop = (HARDWIRED_ZERO != 0)
                  && (bus.write_register_address_in == '0);
  assign user_wr = (state_q == RF_IDLE) && bus.write_enable_in
                && !bus.clear_request_in && !zero_drop;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= RF_CLEARING;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    unique case (state_q)
      RF_CLEARING: begin
        count_d = count_q + AW'(1);
        if (count_q == LAST) begin
          state_d = RF_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        if (bus.clear_request_in) begin
          state_d = RF_CLEARING;
          count_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    wr_en_d   = user_wr;
    wr_addr_d = bus.write_register_address_in;
    wr_data_d = bus.write_data_in;
    if (state_q == RF_CLEARING) begin
      wr_en_d   = 1'b1;
      wr_addr_d = count_q;
      wr_data_d = '0;
    end
  end

  assign bus.busy_out       = (state_q == RF_CLEARING);
  assign bus.clear_done_out = done_q;

  always_ff @(posedge clock_in) begin
    if (!reset_in && wr_en_d) mem_q[wr_addr_d] <= wr_data_d;
  end

  logic [DATA_WIDTH-1:0] entries [NUMBER_OF_REGISTERS];

  for (genvar i = 0; i < NUMBER_OF_REGISTERS; i++) begin : g_entry
    wire [DATA_WIDTH-1:0] entry = mem_q[i];
    assign entries[i] = entry;
  end

  logic [DATA_WIDTH-1:0] rd_data [NUMBER_OF_READ_PORTS];

  for (genvar p = 0; p < NUMBER_OF_READ_PORTS; p++) begin : g_port
    register_file_read_port #(
      .DATA_WIDTH         (DATA_WIDTH),
      .NUMBER_OF_REGISTERS(NUMBER_OF_REGISTERS),
      .ADDR_WIDTH         (AW),
      .HARDWIRED_ZERO     (HARDWIRED_ZERO),
      .BYPASS_ENABLE      (BYPASS_ENABLE)
    ) u_port (
      .entries_in    (entries),
      .read_addr_in  (bus.read_register_address_in[p]),
      .state_in      (state_q),
      .write_valid_in(user_wr),
      .write_addr_in (bus.write_register_address_in),
      .write_data_in (bus.write_data_in),
      .read_data_out (rd_data[p])
    );
  end

  always_comb begin
    for (int p = 0; p < NUMBER_OF_READ_PORTS; p++) begin
      bus.read_data_out[p] = rd_data[p];
    end
  end

endmodule

// File: tb/tb_param_register_file.sv
// tb_param_register_file: bench for three 8-bit/256-entry variants
// (zero+bypass, neither, bypass only) and a 32-bit/16-entry/3-port variant.
module tb_param_register_file;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  logic       clr, we;
  logic [7:0] wa, wd, ra0, ra1;

  logic        dwe;
  logic [3:0]  dwa, dra0, dra1, dra2;
  logic [31:0] dwd;

  logic [3:0] busy_v, done_v;
  logic [7:0] rd0 [3];
  logic [7:0] rd1 [3];
  logic [31:0] drd [3];

  param_register_file_if #(8, 256, 2) if_abc [3] ();
  param_register_file_if #(32, 16, 3) if_d ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign if_abc[g].write_enable_in           = we;
    assign if_abc[g].write_register_address_in = wa;
    assign if_abc[g].write_data_in             = wd;
    assign if_abc[g].read_register_address_in  = {ra1, ra0};
    assign if_abc[g].clear_request_in          = clr;
    assign busy_v[g] = if_abc[g].busy_out;
    assign done_v[g] = if_abc[g].clear_done_out;
    assign rd0[g]    = if_abc[g].read_data_out[0];
    assign rd1[g]    = if_abc[g].read_data_out[1];

    param_register_file #(
      .DATA_WIDTH          (8),
      .NUMBER_OF_REGISTERS (256),
      .NUMBER_OF_READ_PORTS(2),
      .HARDWIRED_ZERO      ((g == 0) ? 1 : 0),
      .BYPASS_ENABLE       ((g == 1) ? 0 : 1)
    ) u_dut (
      .clock_in(clk),
      .reset_in(rst),
      .bus     (if_abc[g].slave)
    );
  end

  assign if_d.write_enable_in           = dwe;
  assign if_d.write_register_address_in = dwa;
  assign if_d.write_data_in             = dwd;
  assign if_d.read_register_address_in  = {dra2, dra1, dra0};
  assign if_d.clear_request_in          = 1'b0;
  assign busy_v[3] = if_d.busy_out;
  assign done_v[3] = if_d.clear_done_out;
  assign drd[0]    = if_d.read_data_out[0];
  assign drd[1]    = if_d.read_data_out[1];
  assign drd[2]    = if_d.read_data_out[2];

  param_register_file #(
    .DATA_WIDTH          (32),
    .NUMBER_OF_REGISTERS (16),
    .NUMBER_OF_READ_PORTS(3),
    .HARDWIRED_ZERO      (1),
    .BYPASS_ENABLE       (1)
  ) u_dut_d (
    .clock_in(clk),
    .reset_in(rst),
    .bus     (if_d.slave)
  );

  typedef struct packed {
    logic [2:0][7:0] p0;
    logic [2:0][7:0] p1;
  } exp_t;

  typedef struct packed {
    logic       we;
    logic [7:0] wa;
    logic [7:0] wd;
    logic [7:0] ra0;
    logic [7:0] ra1;
    exp_t       exp;
  } vec_t;

  exp_t sb [$];
  vec_t vt [7];

  function automatic vec_t mk(
    input logic w, input logic [7:0] a, d, r0, r1,
    input logic [7:0] a0, a1, b0, b1, c0, c1
  );
    vec_t v;
    v.we = w; v.wa = a; v.wd = d; v.ra0 = r0; v.ra1 = r1;
    v.exp.p0 = {c0, b0, a0};
    v.exp.p1 = {c1, b1, a1};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_clear(input string nm, input logic [3:0] mask,
                           input bit inject);
    int hi [4];
    int dn [4];
    bit fell [4];
    bit ok [4];
    int post;
    bit all;
    post = 0;
    for (int i = 0; i < 4; i++) begin
      hi[i] = 0; dn[i] = 0; fell[i] = 0; ok[i] = 0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (inject && cyc == 50) begin
        clr = 1'b1; we = 1'b1; wa = 8'd9; wd = 8'h77; ra0 = 8'd9;
      end else if (inject && cyc == 51) begin
        clr = 1'b0; we = 1'b0;
      end
      #1;
      if (inject && cyc == 50) begin
        for (int g = 0; g < 3; g++)
          chk($sformatf("%s_rd_in_clear_%0d", nm, g), 32'(rd0[g]), 32'h0);
      end
      all = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          if (done_v[i]) dn[i]++;
          if (!fell[i]) begin
            if (busy_v[i]) hi[i]++;
            else begin
              fell[i] = 1'b1;
              ok[i]   = done_v[i];
            end
          end
          if (!fell[i]) all = 1'b0;
        end
      end
      if (all) post++;
      if (post > 3) break;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        chk($sformatf("%s_busy_len_%0d", nm, i), 32'(hi[i]),
            (i == 3) ? 32'd16 : 32'd256);
        chk($sformatf("%s_done_at_fall_%0d", nm, i), 32'(ok[i]), 32'd1);
        chk($sformatf("%s_done_count_%0d", nm, i), 32'(dn[i]), 32'd1);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int dn;

    vt[0] = mk(1, 7,   8'hA5, 7,   8,   8'hA5, 0, 0, 0, 8'hA5, 0);
    vt[1] = mk(0, 0,   0,     7,   8,   8'hA5, 0, 8'hA5, 0, 8'hA5, 0);
    vt[2] = mk(1, 0,   8'hFF, 0,   0,   0, 0, 0, 0, 8'hFF, 8'hFF);
    vt[3] = mk(0, 0,   0,     0,   0,   0, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    vt[4] = mk(1, 3,   8'h11, 3,   7,   8'h11, 8'hA5, 0, 8'hA5, 8'h11, 8'hA5);
    vt[5] = mk(1, 200, 8'h22, 3,   200, 8'h11, 8'h22, 8'h11, 0, 8'h11, 8'h22);
    vt[6] = mk(0, 0,   0,     200, 3,   8'h22, 8'h11, 8'h22, 8'h11, 8'h22, 8'h11);

    rst = 1'b1; clr = 0; we = 0; wa = 0; wd = 0; ra0 = 0; ra1 = 0;
    dwe = 0; dwa = 0; dwd = 0; dra0 = 0; dra1 = 0; dra2 = 0;

    @(posedge clk); #1;
    chk("reset_busy", 32'(busy_v[0]), 32'd1);
    chk("reset_done", 32'(done_v[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_clear("rst", 4'b1111, 0);

    for (int a = 0; a < 256; a++) begin
      ra0 = 8'(a); ra1 = 8'(255 - a);
      #1;
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("zero_%0d_p0_%0d", a, g), 32'(rd0[g]), 32'h0);
        chk($sformatf("zero_%0d_p1_%0d", a, g), 32'(rd1[g]), 32'h0);
      end
    end
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      we = vt[i].we; wa = vt[i].wa; wd = vt[i].wd;
      ra0 = vt[i].ra0; ra1 = vt[i].ra1;
      sb.push_back(vt[i].exp);
      #1;
      e = sb.pop_front();
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("vec%0d_p0_dut%0d", i, g), 32'(rd0[g]), 32'(e.p0[g]));
        chk($sformatf("vec%0d_p1_dut%0d", i, g), 32'(rd1[g]), 32'(e.p1[g]));
      end
      @(posedge clk); #1;
    end

    clr = 1; we = 1; wa = 5; wd = 8'h33; ra0 = 5; ra1 = 3;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("coll_nobypass_%0d", g), 32'(rd0[g]), 32'h0);
      chk($sformatf("coll_old3_%0d", g), 32'(rd1[g]), 32'h11);
    end
    @(posedge clk); #1;
    clr = 0; we = 0; ra0 = 3; ra1 = 200;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("clr_mask3_%0d", g), 32'(rd0[g]), 32'h0);
      chk($sformatf("clr_mask200_%0d", g), 32'(rd1[g]), 32'h0);
    end
    run_clear("clr", 4'b0111, 1);
    ra0 = 3; ra1 = 200;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("after3_%0d", g), 32'(rd0[g]), 32'h0);
      chk($sformatf("after200_%0d", g), 32'(rd1[g]), 32'h0);
    end
    ra0 = 5; ra1 = 9;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("after5_%0d", g), 32'(rd0[g]), 32'h0);
      chk($sformatf("after9_%0d", g), 32'(rd1[g]), 32'h0);
    end

    @(posedge clk); #1;
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    dn = 0;
    for (int k = 0; k < 100; k++) begin
      if (done_v[0]) dn++;
      @(posedge clk); #1;
    end
    chk("mid_no_early_done", 32'(dn), 32'd0);
    chk("mid_busy_before", 32'(busy_v[0]), 32'd1);
    rst = 1;
    @(posedge clk); #1;
    chk("mid_busy_in_reset", 32'(busy_v[0]), 32'd1);
    chk("mid_done_in_reset", 32'(done_v[0]), 32'd0);
    rst = 0;
    run_clear("midrst", 4'b1111, 0);

    @(posedge clk); #1;
    dwe = 1; dwa = 15; dwd = 32'hDEADBEEF;
    dra0 = 15; dra1 = 15; dra2 = 15;
    #1;
    for (int p = 0; p < 3; p++)
      chk($sformatf("sweep_bypass_p%0d", p), drd[p], 32'hDEADBEEF);
    @(posedge clk); #1;
    dwe = 0;
    #1;
    for (int p = 0; p < 3; p++)
      chk($sformatf("sweep_stored_p%0d", p), drd[p], 32'hDEADBEEF);
    dwe = 1; dwa = 0; dwd = 32'h12345678; dra0 = 0; dra1 = 14;
    #1;
    chk("sweep_zero_bypass", drd[0], 32'h0);
    chk("sweep_other", drd[1], 32'h0);
    @(posedge clk); #1;
    dwe = 0;
    #1;
    chk("sweep_zero_stored", drd[0], 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
